jt49_busq: RTL and testbench
============================

Name: jt49_busq

Overview:
- Host-side access queue directly upstream of the jt49 PSG core.
- Accepts register write and read requests from a CPU or sound driver through a valid/ready handshake and buffers them in a FIFO.
- Replays each request onto the PSG's addr/cs_n/wr_n/din port as a single-cycle strobe, with a guaranteed idle gap between strobes.
- Returns read data captured from the PSG dout port.

Parameters:
- AW, 3: FIFO address width; depth = 2**AW entries (default 8).
- GAP, 2: number of clk cycles psg_cs_n stays high between two consecutive strobes; legal range 0..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all queued, not-yet-issued requests
- req_valid  in  1  host request valid
- req_ready  out  1  queue can accept a request
- req_rd  in  1  1 = read request, 0 = write request
- req_addr  in  4  PSG register address
- req_data  in  8  write data; ignored for reads
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  read result
- level  out  AW+1  number of queued entries
- busy  out  1  queue non-empty or an access/gap is in progress
- psg_cs_n  out  1  to PSG cs_n
- psg_wr_n  out  1  to PSG wr_n
- psg_addr  out  4  to PSG addr
- psg_din  out  8  to PSG din
- psg_dout  in  8  from PSG dout, registered by the PSG one cycle after the strobe

Behaviour:
- Reset (rst_n low, asynchronous):
  - psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0.
  - rd_valid=0, rd_data=0, level=0, busy=0.
  - FIFO empty, FSM in IDLE, gap counter 0.
  - req_ready=1.
  - Reset mid-access aborts the access immediately; no rd_valid is produced for it.
- Request acceptance and FIFO:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - Each FIFO entry is 13 bits: {rd, addr, data}.
  - req_ready = !full && !flush.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when neither empty nor full: level unchanged.
  - Read and write pointers are AW bits and wrap modulo 2**AW; level is the occupancy count.
  - flush high: level becomes 0 on the next edge and pointers are equalised; any push in that cycle is dropped. An access already in ACCESS/CAPTURE/GAP completes normally.
- FSM states: IDLE, ACCESS, CAPTURE, GAP.
  - IDLE: if the FIFO is non-empty, pop the head entry and load psg_addr, psg_din, psg_wr_n=rd, psg_cs_n=0; go to ACCESS.
  - ACCESS: lasts exactly one cycle with psg_cs_n=0. Next edge sets psg_cs_n=1 and psg_wr_n=1.
    - For a read, go to CAPTURE.
    - For a write, go to GAP, or to IDLE if GAP=0.
  - CAPTURE: lasts one cycle. psg_dout is valid during this cycle. At its end, rd_data<=psg_dout and rd_valid<=1 for exactly one cycle. Then go to GAP, or to IDLE if GAP=0.
  - GAP: counts GAP cycles with psg_cs_n=1, then goes to IDLE.
  - psg_addr and psg_din hold their last values outside ACCESS.
- Latency:
  - From an empty queue in IDLE, psg_cs_n goes low in the 2nd cycle after the accepting edge (accept at edge 0, FIFO visible in cycle 1, strobe in cycle 2).
  - Read data: rd_valid is asserted 2 cycles after the strobe cycle.
- Throughput:
  - Back-to-back writes issue one strobe every 1+GAP+1 cycles (IDLE consumes 1 cycle).
  - Reads add 1 cycle for CAPTURE.
- Request ordering: strobes issue in strict FIFO order; there is no reordering and no merging.
- busy = (level!=0) || (state!=IDLE).
- Strobe timing versus clk_en: each strobe is exactly 1 clk cycle regardless of the PSG's clk_en. The PSG register file samples on every clk.

Test Plan:
- Single write: after reset, push wr addr=0xD, data=0x0A → psg_cs_n=0, psg_wr_n=0, psg_addr=0xD, psg_din=0x0A for exactly 1 cycle, 2 cycles after accept; busy drops after GAP+1 further cycles.
- Read: PSG model returns 0x5C one cycle after strobe on addr=0x7 → rd_valid pulses once with rd_data=0x5C, exactly 2 cycles after the strobe cycle; psg_wr_n stays 1.
- Backpressure: hold req_valid with PSG strobes stalled by continuous pushing, AW=3 → req_ready=0 once level=8; the 9th request is not accepted until after a pop; all 8 strobes appear in push order with data 0x00..0x07.
- Spacing: push 3 writes back-to-back with GAP=2 → strobes are separated by exactly 3 high cycles of psg_cs_n (GAP + IDLE); with GAP=0 the separation is 1 cycle.
- Flush: queue 5 writes, assert flush during the first strobe → the first strobe completes, no further strobes occur, level=0, a request pushed in the flush cycle is dropped.
- Async reset mid-read: drop rst_n during ACCESS of a read → psg_cs_n=1 immediately without a clock edge, no rd_valid, level=0, req_ready=1 after release.

Source files
------------

// File: rtl/jt49_busq.sv
// Host request queue in front of the jt49 PSG: buffers register reads/writes in a
// FIFO and replays each one as a single-cycle cs_n strobe, followed by an idle gap.
module jt49_busq #(
  parameter int AW  = 3,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rd,
  input  logic [3:0]    req_addr,
  input  logic [7:0]    req_data,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          psg_cs_n,
  output logic          psg_wr_n,
  output logic [3:0]    psg_addr,
  output logic [7:0]    psg_din,
  input  logic [7:0]    psg_dout
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_valid may be held while req_ready is low; the request fields must stay
  // stable until the transfer edge.

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [3:0]    GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_GAP
  } state_t;

  // With GAP=0 the gap state is skipped entirely.
  localparam state_t AFTER_ACCESS = (GAP == 0) ? S_IDLE : S_GAP;

  state_t          state;
  logic [12:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      gap_cnt;
  logic            cur_rd;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head_rd;
  logic [3:0]      head_addr;
  logic [7:0]      head_data;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign req_ready = !full && !flush;
  assign push      = req_valid && req_ready;
  // A flush also stops IDLE from launching the head entry in the same cycle.
  assign pop       = (state == S_IDLE) && !empty && !flush;
  assign busy      = (level != '0) || (state != S_IDLE);
  assign {head_rd, head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_rd, req_addr, req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      psg_addr <= '0;
      psg_din  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      gap_cnt  <= '0;
      cur_rd   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_rd   <= head_rd;
            psg_addr <= head_addr;
            psg_din  <= head_data;
            psg_wr_n <= head_rd;
            psg_cs_n <= 1'b0;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          psg_cs_n <= 1'b1;
          psg_wr_n <= 1'b1;
          gap_cnt  <= '0;
          state    <= cur_rd ? S_CAPTURE : AFTER_ACCESS;
        end
        S_CAPTURE: begin
          // The PSG registered dout on the strobe edge, so it is stable now.
          rd_data  <= psg_dout;
          rd_valid <= 1'b1;
          state    <= AFTER_ACCESS;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt49_busq.sv
// Self-checking bench for jt49_busq: scoreboard of expected strobes and read data,
// a small PSG register model, table-driven traffic and hand-written corner sequences.
module tb_jt49_busq;

  localparam int AW  = 3;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rd = 1'b0;
  logic [3:0]    req_addr = '0;
  logic [7:0]    req_data = '0;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [AW:0]   level;
  logic          busy;
  logic          psg_cs_n;
  logic          psg_wr_n;
  logic [3:0]    psg_addr;
  logic [7:0]    psg_din;
  logic [7:0]    psg_dout = '0;

  // Second instance with GAP=0, writes only
  logic          req_valid0 = 1'b0;
  logic          flush0 = 1'b0;
  logic          req_rd0 = 1'b0;
  logic [3:0]    req_addr0 = '0;
  logic [7:0]    req_data0 = '0;
  logic [7:0]    psg_dout0 = '0;
  logic          req_ready0, rd_valid0, busy0, psg_cs_n0, psg_wr_n0;
  logic [7:0]    rd_data0, psg_din0;
  logic [AW:0]   level0;
  logic [3:0]    psg_addr0;

  jt49_busq #(.AW(AW), .GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_addr(req_addr), .req_data(req_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .busy(busy),
    .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n), .psg_addr(psg_addr),
    .psg_din(psg_din), .psg_dout(psg_dout)
  );

  jt49_busq #(.AW(AW), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_rd(req_rd0),
    .req_addr(req_addr0), .req_data(req_data0),
    .rd_valid(rd_valid0), .rd_data(rd_data0), .level(level0), .busy(busy0),
    .psg_cs_n(psg_cs_n0), .psg_wr_n(psg_wr_n0), .psg_addr(psg_addr0),
    .psg_din(psg_din0), .psg_dout(psg_dout0)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cyc = 0;
  bit          saw_full = 1'b0;
  logic [12:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  int          rd_strobe_q[$];
  int          strobe_cyc_q[$];
  int          s0_cyc_q[$];
  logic [7:0]  s0_din_q[$];
  logic [7:0]  psg_regs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- PSG register model ----------------
  always @(posedge clk) begin
    if (!psg_cs_n) begin
      if (!psg_wr_n) psg_regs[psg_addr] <= psg_din;
      else           psg_dout <= psg_regs[psg_addr];
    end
  end

  // ---------------- output monitor ----------------
  logic [12:0] mon_exp;
  logic [7:0]  mon_rd;
  int          mon_s;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!psg_cs_n) begin
        strobe_cyc_q.push_back(cyc);
        check("strobe_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("strobe_word", {psg_wr_n, psg_addr, psg_din}, mon_exp);
        end
        if (psg_wr_n) rd_strobe_q.push_back(cyc);
      end
      if (rd_valid) begin
        check("rd_pending", (exp_rd_q.size() != 0 && rd_strobe_q.size() != 0), 1);
        if (exp_rd_q.size() != 0 && rd_strobe_q.size() != 0) begin
          mon_rd = exp_rd_q.pop_front();
          mon_s  = rd_strobe_q.pop_front();
          check("rd_data", rd_data, mon_rd);
          check("rd_latency", cyc, mon_s + 2);
        end
      end
      if (!req_ready && !flush) begin
        saw_full = 1'b1;
        check("full_level", level, 8);
      end
      if (!psg_cs_n0) begin
        s0_cyc_q.push_back(cyc);
        s0_din_q.push_back(psg_din0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic rd, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] er, input bit track);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_rd    = rd;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        done    = 1'b1;
        acc_cyc = cyc;
        if (track) begin
          exp_q.push_back({rd, a, d});
          if (rd) exp_rd_q.push_back(er);
        end
      end
    end
    check("push_accept", done, 1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
    end
    check({name, "_idle"}, done, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    for (int i = 0; i < 16; i++) psg_regs[i] = 8'h00;
    psg_regs[7] = 8'h5C;

    tbl[0] = '{1'b0, 4'h0, 8'h11, 8'h00};
    tbl[1] = '{1'b0, 4'h1, 8'h22, 8'h00};
    tbl[2] = '{1'b1, 4'h7, 8'h00, 8'h5C};
    tbl[3] = '{1'b1, 4'h0, 8'h00, 8'h11};
    tbl[4] = '{1'b1, 4'h1, 8'h00, 8'h22};
    tbl[5] = '{1'b0, 4'h7, 8'h99, 8'h00};
    tbl[6] = '{1'b1, 4'h7, 8'h00, 8'h99};
    tbl[7] = '{1'b0, 4'hF, 8'hC3, 8'h00};

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cs_n", psg_cs_n, 1);
    check("rst_wr_n", psg_wr_n, 1);
    check("rst_addr", psg_addr, 0);
    check("rst_din", psg_din, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);

    // single write: strobe one cycle after the accepting edge, busy clears GAP+1 later
    @(posedge clk); #1;
    push(1'b0, 4'hD, 8'h0A, 8'h00, 1'b1);
    req_valid = 1'b0;
    a = acc_cyc;
    check("sw_pre_strobe", psg_cs_n, 1);
    @(posedge clk); #1;
    check("sw_strobe_cs", psg_cs_n, 0);
    check("sw_strobe_wr", psg_wr_n, 0);
    check("sw_strobe_addr", psg_addr, 4'hD);
    check("sw_strobe_din", psg_din, 8'h0A);
    check("sw_strobe_cycle", cyc, a + 1);
    @(posedge clk); #1;
    check("sw_strobe_len", psg_cs_n, 1);
    check("sw_busy_gap1", busy, 1);
    @(posedge clk); #1;
    check("sw_busy_gap2", busy, 1);
    @(posedge clk); #1;
    check("sw_busy_done", busy, 0);

    // table-driven mixed traffic
    for (int i = 0; i < 8; i++) push(tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].exp_rd, 1'b1);
    req_valid = 1'b0;
    wait_idle("tbl");
    check("tbl_strobes_left", exp_q.size(), 0);
    check("tbl_reads_left", exp_rd_q.size(), 0);

    // backpressure: pushes outpace the drain until the queue is full
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) push(1'b0, 4'h3, 8'(i), 8'h00, 1'b1);
    req_valid = 1'b0;
    wait_idle("bp");
    check("bp_saw_full", saw_full, 1);
    check("bp_strobes_left", exp_q.size(), 0);

    // spacing with GAP=2
    strobe_cyc_q.delete();
    for (int i = 0; i < 3; i++) push(1'b0, 4'h8, 8'(8'h40 + i), 8'h00, 1'b1);
    req_valid = 1'b0;
    wait_idle("sp");
    check("sp_count", strobe_cyc_q.size(), 3);
    if (strobe_cyc_q.size() == 3) begin
      check("sp_gap_01", strobe_cyc_q[1] - strobe_cyc_q[0], 4);
      check("sp_gap_12", strobe_cyc_q[2] - strobe_cyc_q[1], 4);
    end

    // spacing with GAP=0 on the second instance
    for (int i = 0; i < 3; i++) begin
      req_valid0 = 1'b1;
      req_addr0  = 4'(i);
      req_data0  = 8'(8'hA0 + i);
      check("g0_ready", req_ready0, 1);
      @(posedge clk); #1;
    end
    req_valid0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("g0_count", s0_cyc_q.size(), 3);
    if (s0_cyc_q.size() == 3) begin
      check("g0_gap_01", s0_cyc_q[1] - s0_cyc_q[0], 2);
      check("g0_gap_12", s0_cyc_q[2] - s0_cyc_q[1], 2);
      check("g0_din_0", s0_din_q[0], 8'hA0);
      check("g0_din_2", s0_din_q[2], 8'hA2);
    end

    // flush during the first strobe of five queued writes
    push(1'b0, 4'h1, 8'h50, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) push(1'b0, 4'h2, 8'(8'h60 + i), 8'h00, (i == 0));
    check("fl_strobe_cs", psg_cs_n, 0);
    check("fl_strobe_din", psg_din, 8'h60);
    check("fl_level_before", level, 4);
    flush    = 1'b1;
    req_data = 8'hEE;
    #1;
    check("fl_ready_low", req_ready, 0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("fl_level_after", level, 0);
    wait_idle("fl");
    repeat (10) @(posedge clk);
    #1;
    check("fl_level_end", level, 0);
    check("fl_strobes_left", exp_q.size(), 0);

    // asynchronous reset in the middle of a read access
    push(1'b1, 4'h7, 8'h00, 8'h00, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("ar_strobe_cs", psg_cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cs_n_async", psg_cs_n, 1);
    check("ar_wr_n_async", psg_wr_n, 1);
    check("ar_level_async", level, 0);
    check("ar_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("ar_level_rel", level, 0);
    check("ar_ready_rel", req_ready, 1);
    check("ar_rd_valid", rd_valid, 0);
    check("ar_reads_left", exp_rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
